// File: rtl/mem_stage.sv
// ---------------------------------------------------------------------------
// mem_stage -- MEM pipeline stage with an integrated data memory and the
// MEM/WB pipeline register.
//
// Ports
//   i_clk, i_reset          clock (rising edge), async active-high reset
//   i_enable                stage advance; low freezes MEM/WB and blocks stores
//   i_ex_m_alu_result       byte address for loads/stores, ALU value otherwise
//   i_ex_m_write_data       store data (low byte/half used for SB/SH)
//   i_ex_m_rd               destination register
//   i_ex_m_mem_read/write   load / store request (both high = store only)
//   i_ex_m_mem_to_reg       WB source select
//   i_ex_m_reg_write        WB register write enable
//   i_ex_m_bhw_type         000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
//   o_m_wb_*                registered MEM/WB fields
//   o_m_wb_data_write       combinational WB value (for EX forwarding)
//   o_misaligned            registered flag for a misaligned/invalid access
//
// Memory is little-endian, MEM_DEPTH 32-bit words (power of two assumed);
// address bits above the memory size are ignored so accesses wrap. Memory
// is not reset.
// ---------------------------------------------------------------------------
module mem_stage #(
    parameter int MEM_DEPTH = 256
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_enable,
    input  logic [31:0] i_ex_m_alu_result,
    input  logic [31:0] i_ex_m_write_data,
    input  logic [4:0]  i_ex_m_rd,
    input  logic        i_ex_m_mem_read,
    input  logic        i_ex_m_mem_write,
    input  logic        i_ex_m_mem_to_reg,
    input  logic        i_ex_m_reg_write,
    input  logic [2:0]  i_ex_m_bhw_type,
    output logic [31:0] o_m_wb_read_data,
    output logic [31:0] o_m_wb_alu_result,
    output logic [4:0]  o_m_wb_rd,
    output logic        o_m_wb_mem_to_reg,
    output logic        o_m_wb_reg_write,
    output logic [31:0] o_m_wb_data_write,
    output logic        o_misaligned
);

    localparam int AW = $clog2(4 * MEM_DEPTH);   // byte address width
    localparam int IW = AW - 2;                   // word index width

    logic [31:0] mem_q [MEM_DEPTH];

    logic [IW-1:0] idx;
    logic [1:0]    lane;
    logic          type_ok, aligned, access_ok, bad_access;
    logic          store_en, load_en;
    logic [3:0]    byte_en;
    logic [31:0]   wr_lanes;
    logic [31:0]   rd_word, rd_shift, load_val;

    // MEM/WB next-state
    logic [31:0] read_data_d, alu_result_d;
    logic [4:0]  rd_d;
    logic        mem_to_reg_d, reg_write_d, misaligned_d;

    // MEM/WB state
    logic [31:0] read_data_q, alu_result_q;
    logic [4:0]  rd_q;
    logic        mem_to_reg_q, reg_write_q, misaligned_q;

    // Upper address bits are deliberately ignored (address wrap).
    logic unused_addr;
    assign unused_addr = ^i_ex_m_alu_result[31:AW];

    assign idx  = i_ex_m_alu_result[AW-1:2];
    assign lane = i_ex_m_alu_result[1:0];

    // Access type decode and alignment
    always_comb begin
        type_ok = 1'b0;
        aligned = 1'b0;
        case (i_ex_m_bhw_type)
            3'b000, 3'b100: begin type_ok = 1'b1; aligned = 1'b1;           end
            3'b001, 3'b101: begin type_ok = 1'b1; aligned = ~lane[0];       end
            3'b010:         begin type_ok = 1'b1; aligned = (lane == 2'b00); end
            default:        begin type_ok = 1'b0; aligned = 1'b0;           end
        endcase
    end

    assign access_ok  = type_ok & aligned;
    assign bad_access = (i_ex_m_mem_read | i_ex_m_mem_write) & ~access_ok;
    // Reset gating keeps a store from landing on an edge that sees reset high.
    assign store_en   = i_ex_m_mem_write & access_ok & i_enable & ~i_reset;
    // A simultaneous read+write request is a store; the read is dropped.
    assign load_en    = i_ex_m_mem_read & ~i_ex_m_mem_write & access_ok;

    // Lane enables and data replicated across lanes so the enables pick it.
    always_comb begin
        byte_en  = 4'b0000;
        wr_lanes = i_ex_m_write_data;
        case (i_ex_m_bhw_type[1:0])
            2'b00: begin
                byte_en  = 4'b0001 << lane;
                wr_lanes = {4{i_ex_m_write_data[7:0]}};
            end
            2'b01: begin
                byte_en  = lane[1] ? 4'b1100 : 4'b0011;
                wr_lanes = {2{i_ex_m_write_data[15:0]}};
            end
            default: begin
                byte_en  = 4'b1111;
                wr_lanes = i_ex_m_write_data;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (store_en) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) mem_q[idx][8*b +: 8] <= wr_lanes[8*b +: 8];
            end
        end
    end

    // Load extraction: shift the addressed lane(s) down, then extend.
    assign rd_word  = mem_q[idx];
    assign rd_shift = rd_word >> {lane, 3'b000};

    always_comb begin
        case (i_ex_m_bhw_type)
            3'b000:  load_val = {{24{rd_shift[7]}}, rd_shift[7:0]};
            3'b100:  load_val = {24'd0, rd_shift[7:0]};
            3'b001:  load_val = {{16{rd_shift[15]}}, rd_shift[15:0]};
            3'b101:  load_val = {16'd0, rd_shift[15:0]};
            default: load_val = rd_word;
        endcase
    end

    always_comb begin
        read_data_d  = load_en ? load_val : 32'd0;
        alu_result_d = i_ex_m_alu_result;
        rd_d         = i_ex_m_rd;
        mem_to_reg_d = i_ex_m_mem_to_reg;
        // A faulting load must not write back; faulting stores pass through.
        reg_write_d  = i_ex_m_reg_write &
                       ~(i_ex_m_mem_read & ~i_ex_m_mem_write & ~access_ok);
        misaligned_d = bad_access;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            read_data_q  <= 32'd0;
            alu_result_q <= 32'd0;
            rd_q         <= 5'd0;
            mem_to_reg_q <= 1'b0;
            reg_write_q  <= 1'b0;
            misaligned_q <= 1'b0;
        end else if (i_enable) begin
            read_data_q  <= read_data_d;
            alu_result_q <= alu_result_d;
            rd_q         <= rd_d;
            mem_to_reg_q <= mem_to_reg_d;
            reg_write_q  <= reg_write_d;
            misaligned_q <= misaligned_d;
        end
    end

    assign o_m_wb_read_data  = read_data_q;
    assign o_m_wb_alu_result = alu_result_q;
    assign o_m_wb_rd         = rd_q;
    assign o_m_wb_mem_to_reg = mem_to_reg_q;
    assign o_m_wb_reg_write  = reg_write_q;
    assign o_misaligned      = misaligned_q;
    assign o_m_wb_data_write = mem_to_reg_q ? read_data_q : alu_result_q;

endmodule
